// File: rtl/prefix_sum_resolve.sv
// rtl/prefix_sum_resolve.sv - carry resolve, sum and overflow back end of a parallel-prefix adder
// Optional feature macro: PREFIX_SUM_SATURATE_EN (signed saturation of the sum on overflow).
// Two register stages with a valid/ready handshake, one operation per clock.
module prefix_sum_resolve #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] p_half,
  input  logic [N-1:0] g_grp,
  input  logic [N-1:0] p_grp,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [N:0]   carry;
  logic         valid_a;
  logic [N-1:0] p_half_a;
  logic [N:0]   c_a;
  logic         en_a;
  logic         en_b;
  logic         accept;
  logic [N-1:0] sum_wrap;
  logic [N-1:0] sum_next;
  logic         ovf_next;

  // Resolve every carry from the group generate/propagate terms and the carry-in.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i <= N; i++) begin
      carry[i] = g_grp[i-1] | (p_grp[i-1] & cin);
    end
  end

  // Stage B advances when empty or being drained; stage A when empty or stage B advances.
  assign en_b     = ~out_valid | out_ready;
  assign en_a     = ~valid_a | en_b;
  assign in_ready = en_a & reset_n;
  assign accept   = in_valid & in_ready;

  assign sum_wrap = p_half_a ^ c_a[N-1:0];
  assign ovf_next = c_a[N] ^ c_a[N-1];

`ifdef PREFIX_SUM_SATURATE_EN
  // On overflow clamp to the most negative value when both operands were negative, else the most positive.
  always_comb begin
    sum_next = sum_wrap;
    if (ovf_next) begin
      sum_next = c_a[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end
`else
  assign sum_next = sum_wrap;
`endif

  // Stage A: capture half-sum and resolved carries on accept; bubble when allowed to move but nothing arrives.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_a  <= 1'b0;
      p_half_a <= '0;
      c_a      <= '0;
    end else if (en_a) begin
      valid_a <= accept;
      if (accept) begin
        p_half_a <= p_half;
        c_a      <= carry;
      end
    end
  end

  // Stage B: form sum, carry-out and overflow from stage A; hold everything while stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en_b) begin
      out_valid <= valid_a;
      if (valid_a) begin
        sum  <= sum_next;
        cout <= c_a[N];
        ovf  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_prefix_sum_resolve.sv
// tb/tb_prefix_sum_resolve.sv - scoreboard bench for prefix_sum_resolve with directed vectors
module tb_prefix_sum_resolve;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] p_half;
  logic [7:0] g_grp;
  logic [7:0] p_grp;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef PREFIX_SUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  prefix_sum_resolve #(.N(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .p_half(p_half), .g_grp(g_grp), .p_grp(p_grp), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream prefix network stand-in: group generate/propagate from the operands.
  task automatic set_operands(input logic [7:0] a, input logic [7:0] b);
    logic gacc, pacc;
    gacc = 1'b0;
    pacc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gacc     = (a[i] & b[i]) | ((a[i] ^ b[i]) & gacc);
      pacc     = (a[i] ^ b[i]) & pacc;
      g_grp[i] = gacc;
      p_grp[i] = pacc;
    end
    p_half = a ^ b;
  endtask

  function automatic res_t mk(input logic [7:0] s_wrap, input logic [7:0] s_sat,
                              input logic co, input logic ov);
    res_t r;
    r.sum  = SAT ? s_sat : s_wrap;
    r.cout = co;
    r.ovf  = ov;
    return r;
  endfunction

  // One clock of stimulus; pushes the expected result when the operation is accepted.
  task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic ordy, input res_t e, output logic acc);
    @(posedge clk);
    #1;
    in_valid = iv;
    if (iv) set_operands(a, b);
    else begin
      p_half = 8'hA5; g_grp = 8'h5A; p_grp = 8'hC3;
    end
    cin       = iv ? c : 1'b1;
    out_ready = ordy;
    @(negedge clk);
    acc = iv && in_ready;
    if (acc) exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic ordy, input res_t e);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      step(1'b1, a, b, c, ordy, e, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 8'h00, 8'h00, 1'b0, ordy, res_t'(0), acc);
  endtask

  // Monitor: whenever a result is presented it must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", {23'd0, sum, cout, ovf}, 32'hFFFF_FFFF);
        end else begin
          chk("result", {23'd0, sum, cout, ovf},
              {23'd0, exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf});
          if (out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic iv_pat [6];
    logic ov_pat [6];

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    p_half = '0; g_grp = '0; p_grp = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_outputs", {23'd0, sum, cout, ovf}, 32'd0);
    chk("reset_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Directed vectors, back to back with no backpressure.
    send(8'h35, 8'h4A, 1'b0, 1'b1, mk(8'h7F, 8'h7F, 1'b0, 1'b0));
    send(8'h35, 8'h4A, 1'b1, 1'b1, mk(8'h80, 8'h7F, 1'b0, 1'b1));
    send(8'hFF, 8'h01, 1'b0, 1'b1, mk(8'h00, 8'h00, 1'b1, 1'b0));
    send(8'h80, 8'hFF, 1'b0, 1'b1, mk(8'h7F, 8'h80, 1'b1, 1'b1));
    send(8'h7F, 8'h01, 1'b0, 1'b1, mk(8'h80, 8'h7F, 1'b0, 1'b1));
    send(8'hF0, 8'h0F, 1'b1, 1'b1, mk(8'h00, 8'h00, 1'b1, 1'b0));
    send(8'h12, 8'h34, 1'b1, 1'b1, mk(8'h47, 8'h47, 1'b0, 1'b0));
    repeat (3) idle(1'b1);
    chk("drain_directed", exp_q.size(), 32'd0);

    // Backpressure: two accepts fill the pipe, then in_ready stays low while stalled.
    send(8'h01, 8'h00, 1'b0, 1'b0, mk(8'h01, 8'h01, 1'b0, 1'b0));
    send(8'h02, 8'h00, 1'b0, 1'b0, mk(8'h02, 8'h02, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h03, 8'h00, 1'b0, 1'b0, mk(8'h03, 8'h03, 1'b0, 1'b0), acc);
      chk("bp_in_ready_low", {31'd0, acc}, 32'd0);
      chk("bp_hold_sum", {24'd0, sum}, 32'h01);
    end
    step(1'b1, 8'h03, 8'h00, 1'b0, 1'b1, mk(8'h03, 8'h03, 1'b0, 1'b0), acc);
    chk("bp_release_accept3", {31'd0, acc}, 32'd1);
    chk("bp_consec_0", {31'd0, out_valid}, 32'd1);
    step(1'b1, 8'h04, 8'h00, 1'b0, 1'b1, mk(8'h04, 8'h04, 1'b0, 1'b0), acc);
    chk("bp_release_accept4", {31'd0, acc}, 32'd1);
    chk("bp_consec_1", {31'd0, out_valid}, 32'd1);
    idle(1'b1);
    chk("bp_consec_2", {31'd0, out_valid}, 32'd1);
    idle(1'b1);
    chk("bp_consec_3", {31'd0, out_valid}, 32'd1);
    idle(1'b1);
    chk("bp_drained", exp_q.size(), 32'd0);

    // Reset with both stages occupied: nothing in flight may surface afterwards.
    send(8'h11, 8'h22, 1'b0, 1'b0, mk(8'h33, 8'h33, 1'b0, 1'b0));
    send(8'h01, 8'h02, 1'b0, 1'b0, mk(8'h03, 8'h03, 1'b0, 1'b0));
    @(posedge clk);
    #1 reset_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 exp_q.delete(); reset_n = 1'b1;
    @(negedge clk);
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_outputs", {23'd0, sum, cout, ovf}, 32'd0);
    chk("midreset_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Bubbles: out_valid follows in_valid two cycles later.
    iv_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int t = 0; t < 6; t++) begin
      step(iv_pat[t], 8'(t + 8), 8'h00, 1'b0, 1'b1, mk(8'(t + 8), 8'(t + 8), 1'b0, 1'b0), acc);
      ov_pat[t] = out_valid;
    end
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("bubble_latency_%0d", t), {31'd0, ov_pat[t+2]}, {31'd0, iv_pat[t]});
    end

    repeat (3) idle(1'b1);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
